// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner: per-channel offset/gain correction of raw ADC
// codes followed by a per-channel box-car average of 2^AVG_LOG2 samples.
// Ports:
//   clk, iRST                  clock, asynchronous active-high reset
//   in_valid/in_ch/in_data     raw sample strobe, channel tag, unsigned code
//   cfg_we/cfg_ch              runtime calibration write for one channel
//   cfg_offset/cfg_gain        signed offset and signed gain (1e-6 units)
//   out_valid/out_ch           averaged-result strobe and its channel
//   out_result                 offset-corrected code of the completing sample
//   out_prod                   averaged scaled value
//   ch_err                     sticky flag: sample seen with in_ch >= CH
module adc_sample_conditioner #(
   parameter int ADC_W      = 12,
   parameter int GAIN_W     = 15,
   parameter int CH         = 4,
   parameter int AVG_LOG2   = 2,
   parameter int DEF_OFFSET = 3041,
   parameter int DEF_GAIN   = 6268,
   localparam int CHW       = (CH > 1) ? $clog2(CH) : 1,
   localparam int RES_W     = ADC_W + 1,
   localparam int PROD_W    = RES_W + GAIN_W,
   localparam int ACC_W     = PROD_W + AVG_LOG2
) (
   input  logic              clk,
   input  logic              iRST,
   input  logic              in_valid,
   input  logic [CHW-1:0]    in_ch,
   input  logic [ADC_W-1:0]  in_data,
   input  logic              cfg_we,
   input  logic [CHW-1:0]    cfg_ch,
   input  logic [RES_W-1:0]  cfg_offset,
   input  logic [GAIN_W-1:0] cfg_gain,
   output logic              out_valid,
   output logic [CHW-1:0]    out_ch,
   output logic [RES_W-1:0]  out_result,
   output logic [PROD_W-1:0] out_prod,
   output logic              ch_err
);

   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [CHW:0] CH_LIM = (CHW + 1)'(CH);

   logic signed [RES_W-1:0]  offset [CH];
   logic signed [GAIN_W-1:0] gain   [CH];
   logic signed [ACC_W-1:0]  acc    [CH];
   logic [CNT_W-1:0]         cnt    [CH];

   logic                     s1_valid;
   logic [CHW-1:0]           s1_ch;
   logic signed [RES_W-1:0]  s1_res;
   logic signed [GAIN_W-1:0] s1_gain;

   logic                     s2_valid;
   logic [CHW-1:0]           s2_ch;
   logic signed [RES_W-1:0]  s2_res;
   logic signed [PROD_W-1:0] s2_prod;

   logic                     in_range;
   logic                     accept;
   logic                     s1_keep;
   logic                     s2_done;
   logic signed [RES_W-1:0]  res_next;
   logic signed [PROD_W-1:0] prod_next;
   logic signed [ACC_W-1:0]  sum;

   assign in_range = {1'b0, in_ch} < CH_LIM;

   // A calibration write kills any same-channel sample still ahead of
   // the accumulator, so no average mixes old and new calibration.
   assign accept  = in_valid && in_range && !(cfg_we && cfg_ch == in_ch);
   assign s1_keep = s1_valid && !(cfg_we && cfg_ch == s1_ch);

   assign res_next = $signed({1'b0, in_data}) - offset[in_ch];

   // Operands widened to the product width keep the low bits exact.
   assign prod_next = $signed({{GAIN_W{s1_res[RES_W-1]}}, s1_res})
                    * $signed({{RES_W{s1_gain[GAIN_W-1]}}, s1_gain});

   assign sum     = acc[s2_ch] + ACC_W'(s2_prod);
   assign s2_done = s2_valid && (cnt[s2_ch] == CNT_LAST);

   always_ff @(posedge clk or posedge iRST) begin
      if (iRST) begin
         for (int c = 0; c < CH; c++) begin
            offset[c] <= RES_W'(DEF_OFFSET);
            gain[c]   <= GAIN_W'(DEF_GAIN);
         end
      end else if (cfg_we) begin
         offset[cfg_ch] <= cfg_offset;
         gain[cfg_ch]   <= cfg_gain;
      end
   end

   always_ff @(posedge clk or posedge iRST) begin
      if (iRST) begin
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_res   <= '0;
         s1_gain  <= '0;
         s2_valid <= 1'b0;
         s2_ch    <= '0;
         s2_res   <= '0;
         s2_prod  <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_ch   <= in_ch;
            s1_res  <= res_next;
            s1_gain <= gain[in_ch];
         end
         s2_valid <= s1_keep;
         if (s1_keep) begin
            s2_ch   <= s1_ch;
            s2_res  <= s1_res;
            s2_prod <= prod_next;
         end
      end
   end

   // Clear from a calibration write is applied last so it wins over
   // an increment from a sample landing in the same cycle.
   always_ff @(posedge clk or posedge iRST) begin
      if (iRST) begin
         for (int c = 0; c < CH; c++) begin
            acc[c] <= '0;
            cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (s2_valid && s2_ch == CHW'(c)) begin
               if (s2_done) begin
                  acc[c] <= '0;
                  cnt[c] <= '0;
               end else begin
                  acc[c] <= sum;
                  cnt[c] <= cnt[c] + 1'b1;
               end
            end
            if (cfg_we && cfg_ch == CHW'(c)) begin
               acc[c] <= '0;
               cnt[c] <= '0;
            end
         end
      end
   end

   // Arithmetic shift floors toward -inf; the truncation is lossless
   // because the average of PROD_W-bit values fits in PROD_W bits.
   always_ff @(posedge clk or posedge iRST) begin
      if (iRST) begin
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_result <= '0;
         out_prod   <= '0;
         ch_err     <= 1'b0;
      end else begin
         out_valid <= s2_done;
         if (s2_done) begin
            out_ch     <= s2_ch;
            out_result <= s2_res;
            out_prod   <= PROD_W'(sum >>> AVG_LOG2);
         end
         if (in_valid && !in_range) begin
            ch_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// tb_adc_sample_conditioner: random and directed checks of the
// conditioner against a sample-level reference model.
module tb_adc_sample_conditioner;

   localparam int CH     = 3;
   localparam int N      = 4;
   localparam int ADC_W  = 12;
   localparam int GAIN_W = 15;
   localparam int RES_W  = 13;
   localparam int PROD_W = 28;
   localparam int CHW    = 2;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic [CHW-1:0] in_ch;
   logic [ADC_W-1:0] in_data;
   logic cfg_we;
   logic [CHW-1:0] cfg_ch;
   logic [RES_W-1:0] cfg_offset;
   logic [GAIN_W-1:0] cfg_gain;

   logic a_valid, b_valid, a_err, b_err;
   logic [CHW-1:0] a_ch, b_ch;
   logic [RES_W-1:0] a_res, b_res;
   logic [PROD_W-1:0] a_prod, b_prod;

   always #5 clk = ~clk;

   adc_sample_conditioner #(.CH(CH), .AVG_LOG2(0)) dut_a (
      .clk(clk), .iRST(rst),
      .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_offset(cfg_offset), .cfg_gain(cfg_gain),
      .out_valid(a_valid), .out_ch(a_ch), .out_result(a_res),
      .out_prod(a_prod), .ch_err(a_err)
   );

   adc_sample_conditioner #(.CH(CH), .AVG_LOG2(2)) dut_b (
      .clk(clk), .iRST(rst),
      .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_offset(cfg_offset), .cfg_gain(cfg_gain),
      .out_valid(b_valid), .out_ch(b_ch), .out_result(b_res),
      .out_prod(b_prod), .ch_err(b_err)
   );

   // Reference model for dut_b: a list of accepted samples stamped with
   // their accept cycle; a sample is folded into its channel average two
   // cycles after acceptance, and a calibration write drops younger ones.
   typedef struct {
      int     ch;
      longint res;
      longint gain;
      int     t;
   } smp_t;

   smp_t   q[$];
   longint m_off[CH];
   longint m_gain[CH];
   longint m_acc[CH];
   int     m_cnt[CH];
   bit     m_err;
   int     cyc;
   bit     e_v;
   int     e_ch;
   longint e_res;
   longint e_prod;
   int     n_chk;
   int     n_fail;

   function automatic longint wrap(longint x, int w);
      longint m, r;
      m = longint'(1) << w;
      r = ((x % m) + m) % m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   function automatic longint floor_div(longint s, longint d);
      longint r;
      r = s / d;
      if ((s % d) != 0 && s < 0) r -= 1;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      for (int c = 0; c < CH; c++) begin
         m_off[c]  = 3041;
         m_gain[c] = 6268;
         m_acc[c]  = 0;
         m_cnt[c]  = 0;
      end
      m_err = 1'b0;
      e_v   = 1'b0;
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      in_ch      = '0;
      in_data    = '0;
      cfg_we     = 1'b0;
      cfg_ch     = '0;
      cfg_offset = '0;
      cfg_gain   = '0;
   endtask

   // Drives one clock of stimulus, advances the model, returns #1 after
   // the edge with e_* holding the output the model expects now.
   task automatic step(input int v, input int ch, input int data,
                       input int we, input int cch,
                       input longint off, input longint g);
      longint prod;
      int i;
      in_valid   = v[0];
      in_ch      = ch[CHW-1:0];
      in_data    = data[ADC_W-1:0];
      cfg_we     = we[0];
      cfg_ch     = cch[CHW-1:0];
      cfg_offset = off[RES_W-1:0];
      cfg_gain   = g[GAIN_W-1:0];
      e_v = 1'b0;
      i = 0;
      while (i < q.size()) begin
         if (q[i].t == cyc - 2) begin
            prod = q[i].res * q[i].gain;
            if (m_cnt[q[i].ch] == N - 1) begin
               e_v    = 1'b1;
               e_ch   = q[i].ch;
               e_res  = q[i].res;
               e_prod = floor_div(m_acc[q[i].ch] + prod, N);
               m_acc[q[i].ch] = 0;
               m_cnt[q[i].ch] = 0;
            end else begin
               m_acc[q[i].ch] += prod;
               m_cnt[q[i].ch] += 1;
            end
            q.delete(i);
         end else begin
            i++;
         end
      end
      if (we != 0) begin
         m_acc[cch] = 0;
         m_cnt[cch] = 0;
         i = 0;
         while (i < q.size()) begin
            if (q[i].ch == cch) q.delete(i);
            else i++;
         end
      end
      if (v != 0) begin
         if (ch >= CH) begin
            m_err = 1'b1;
         end else if (!(we != 0 && cch == ch)) begin
            q.push_back('{ch, wrap(data - m_off[ch], RES_W),
                          m_gain[ch], cyc});
         end
      end
      if (we != 0) begin
         m_off[cch]  = wrap(off, RES_W);
         m_gain[cch] = wrap(g, GAIN_W);
      end
      cyc++;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0 ||
          a_err !== 1'b0 || b_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: a_v=%b b_v=%b a_e=%b b_e=%b want 0",
                  a_valid, b_valid, a_err, b_err);
      end
      n_chk++;
      if (b_ch !== '0 || b_res !== '0 || b_prod !== '0 ||
          a_prod !== '0) begin
         n_fail++;
         $display("FAIL reset_data: ch=%0d res=%0d prod=%0d aprod=%0d want 0",
                  b_ch, b_res, b_prod, a_prod);
      end
      rst = 1'b0;
   endtask

   task automatic test_avg0();
      int data [2] = '{3500, 0};
      longint xr [2] = '{459, -3041};
      longint xp [2] = '{2877012, -19060988};
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) begin
            if (i == 0) step(1, 0, data[k], 0, 0, 0, 0);
            else step(0, 0, 0, 0, 0, 0, 0);
            n_chk++;
            if (a_valid !== (i == 2)) begin
               n_fail++;
               $display("FAIL avg0_valid[%0d,%0d]: got %b want %b",
                        k, i, a_valid, (i == 2));
            end
            n_chk++;
            if (b_valid !== e_v) begin
               n_fail++;
               $display("FAIL avg0_bvalid: got %b want %b", b_valid, e_v);
            end
         end
         n_chk++;
         if (a_ch !== 2'd0 || a_res !== RES_W'(xr[k]) ||
             a_prod !== PROD_W'(xp[k])) begin
            n_fail++;
            $display("FAIL avg0_data[%0d]: ch=%0d res=%0d prod=%0d want 0 %0d %0d",
                     k, a_ch, $signed(a_res), $signed(a_prod), xr[k], xp[k]);
         end
      end
   endtask

   task automatic test_cfg_avg();
      int data [4] = '{3041, 3042, 3043, 3045};
      int outs = 0;
      step(0, 0, 0, 1, 1, 3041, 1000);
      for (int i = 0; i < 7; i++) begin
         if (i < 4) step(1, 1, data[i], 0, 0, 0, 0);
         else step(0, 0, 0, 0, 0, 0, 0);
         n_chk++;
         if (b_valid !== (i == 5)) begin
            n_fail++;
            $display("FAIL cfg_avg_valid[%0d]: got %b want %b",
                     i, b_valid, (i == 5));
         end
         if (b_valid === 1'b1) begin
            outs++;
            n_chk++;
            if (b_ch !== 2'd1 || b_res !== RES_W'(4) ||
                b_prod !== PROD_W'(1750)) begin
               n_fail++;
               $display("FAIL cfg_avg_data: ch=%0d res=%0d prod=%0d want 1 4 1750",
                        b_ch, $signed(b_res), $signed(b_prod));
            end
         end
      end
      n_chk++;
      if (outs != 1) begin
         n_fail++;
         $display("FAIL cfg_avg_count: got %0d want 1", outs);
      end
   endtask

   task automatic test_floor();
      int data [4] = '{1, 1, 1, 0};
      int outs = 0;
      step(0, 0, 0, 1, 2, 2, 1);
      for (int i = 0; i < 7; i++) begin
         if (i < 4) step(1, 2, data[i], 0, 0, 0, 0);
         else step(0, 0, 0, 0, 0, 0, 0);
         n_chk++;
         if (b_valid !== e_v) begin
            n_fail++;
            $display("FAIL floor_valid[%0d]: got %b want %b", i, b_valid, e_v);
         end
         if (b_valid === 1'b1) begin
            outs++;
            n_chk++;
            if (b_ch !== 2'd2 || b_res !== RES_W'(-2) ||
                b_prod !== PROD_W'(-2)) begin
               n_fail++;
               $display("FAIL floor_data: ch=%0d res=%0d prod=%0d want 2 -2 -2",
                        b_ch, $signed(b_res), $signed(b_prod));
            end
         end
      end
      n_chk++;
      if (outs != 1) begin
         n_fail++;
         $display("FAIL floor_count: got %0d want 1", outs);
      end
   endtask

   task automatic test_interleave();
      int outs [CH] = '{0, 0, 0};
      step(0, 0, 0, 1, 0, 3041, 6268);
      step(0, 0, 0, 1, 2, 3041, 6268);
      for (int i = 0; i < 11; i++) begin
         if (i < 8) step(1, (i % 2) * 2, $urandom_range(0, 4095), 0, 0, 0, 0);
         else step(0, 0, 0, 0, 0, 0, 0);
         n_chk++;
         if (b_valid !== e_v) begin
            n_fail++;
            $display("FAIL ilv_valid[%0d]: got %b want %b", i, b_valid, e_v);
         end
         if (e_v) begin
            outs[e_ch]++;
            n_chk++;
            if (b_ch !== CHW'(e_ch) || b_res !== RES_W'(e_res) ||
                b_prod !== PROD_W'(e_prod)) begin
               n_fail++;
               $display("FAIL ilv_data: ch=%0d res=%0d prod=%0d want %0d %0d %0d",
                        b_ch, $signed(b_res), $signed(b_prod),
                        e_ch, e_res, e_prod);
            end
         end
      end
      n_chk++;
      if (outs[0] != 1 || outs[2] != 1 || outs[1] != 0) begin
         n_fail++;
         $display("FAIL ilv_count: got %0d/%0d/%0d want 1/0/1",
                  outs[0], outs[1], outs[2]);
      end
   endtask

   task automatic test_cfg_mid();
      int outs = 0;
      step(0, 0, 0, 1, 0, 3041, 6268);
      step(1, 0, 3500, 0, 0, 0, 0);
      step(1, 0, 3500, 0, 0, 0, 0);
      step(1, 0, 3500, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 3041, 5000);
      for (int i = 0; i < 7; i++) begin
         if (i < 4) step(1, 0, 3045, 0, 0, 0, 0);
         else step(0, 0, 0, 0, 0, 0, 0);
         n_chk++;
         if (b_valid !== (i == 5)) begin
            n_fail++;
            $display("FAIL cfgmid_valid[%0d]: got %b want %b",
                     i, b_valid, (i == 5));
         end
         if (b_valid === 1'b1) begin
            outs++;
            n_chk++;
            if (b_ch !== 2'd0 || b_res !== RES_W'(4) ||
                b_prod !== PROD_W'(20000)) begin
               n_fail++;
               $display("FAIL cfgmid_data: ch=%0d res=%0d prod=%0d want 0 4 20000",
                        b_ch, $signed(b_res), $signed(b_prod));
            end
         end
      end
      n_chk++;
      if (outs != 1) begin
         n_fail++;
         $display("FAIL cfgmid_count: got %0d want 1", outs);
      end
   endtask

   task automatic test_ch_err();
      for (int i = 0; i < 6; i++) begin
         if (i == 0) step(1, CH, 1234, 0, 0, 0, 0);
         else step(0, 0, 0, 0, 0, 0, 0);
         n_chk++;
         if (b_err !== 1'b1 || a_err !== 1'b1 || b_valid !== 1'b0 ||
             a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ch_err[%0d]: a_e=%b b_e=%b a_v=%b b_v=%b want 1 1 0 0",
                     i, a_err, b_err, a_valid, b_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      int outs = 0;
      step(1, 1, 3100, 0, 0, 0, 0);
      step(1, 1, 3100, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (b_err !== 1'b0 || a_err !== 1'b0 || b_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: a_e=%b b_e=%b b_v=%b want 0 0 0",
                  a_err, b_err, b_valid);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) step(1, 1, 3000 + i * 7, 0, 0, 0, 0);
         else step(0, 0, 0, 0, 0, 0, 0);
         n_chk++;
         if (b_valid !== e_v || b_valid !== (i == 5)) begin
            n_fail++;
            $display("FAIL rst_mid_valid[%0d]: got %b want %b",
                     i, b_valid, e_v);
         end
         if (b_valid === 1'b1) begin
            outs++;
            n_chk++;
            if (b_ch !== 2'd1 || b_prod !== PROD_W'(e_prod)) begin
               n_fail++;
               $display("FAIL rst_mid_data: ch=%0d prod=%0d want 1 %0d",
                        b_ch, $signed(b_prod), e_prod);
            end
         end
      end
      n_chk++;
      if (outs != 1) begin
         n_fail++;
         $display("FAIL rst_mid_count: got %0d want 1", outs);
      end
   endtask

   task automatic test_random();
      int v, ch, we;
      longint off, g;
      for (int i = 0; i < 600; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         ch  = $urandom_range(0, 12) == 0 ? CH : $urandom_range(0, CH - 1);
         we  = ($urandom_range(0, 15) == 0);
         off = longint'($urandom_range(0, 8191)) - 4096;
         g   = longint'($urandom_range(0, 32767)) - 16384;
         step(v, ch, $urandom_range(0, 4095), we,
              $urandom_range(0, CH - 1), off, g);
         n_chk++;
         if (b_valid !== e_v || b_err !== m_err) begin
            n_fail++;
            $display("FAIL rnd_flags[%0d]: v=%b e=%b want %b %b",
                     i, b_valid, b_err, e_v, m_err);
         end
         if (e_v) begin
            n_chk++;
            if (b_ch !== CHW'(e_ch) || b_res !== RES_W'(e_res) ||
                b_prod !== PROD_W'(e_prod)) begin
               n_fail++;
               $display("FAIL rnd_data[%0d]: ch=%0d res=%0d prod=%0d want %0d %0d %0d",
                        i, b_ch, $signed(b_res), $signed(b_prod),
                        e_ch, e_res, e_prod);
            end
         end
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      test_reset();
      test_avg0();
      test_cfg_avg();
      test_floor();
      test_interleave();
      test_cfg_mid();
      test_ch_err();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
